alu_share_ctrl: RTL

Arbitration and sequencing controller that shares one ALU-plus-flag-generator datapath between two requesters (e.g. the execute stage and the address/branch unit). It accepts one operation at a time through a valid/ready handshake, drives the shared ALU for one execute cycle, registers the result and Z/N/V/C flags, and returns them to the granted requester. It also maintains the architectural NZCV status register, updated only by operations that request a flag update.

---
 rtl/alu_share_ctrl_if.sv | 44 ++++
 rtl/alu_share_ctrl.sv | 94 +++++++++
 2 files changed

// File: rtl/alu_share_ctrl_if.sv
// Bundle of requester handshakes, shared-ALU drive/return and status signals
// for alu_share_ctrl; slave is the controller side, master the environment.
interface alu_share_ctrl_if #(
   parameter int unsigned M = 4
);
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [3:0]   req_op0;
   logic [3:0]   req_op1;
   logic [M-1:0] req_a0;
   logic [M-1:0] req_b0;
   logic [M-1:0] req_a1;
   logic [M-1:0] req_b1;
   logic [1:0]   req_setf;
   logic [3:0]   alu_ctrl;
   logic [M-1:0] alu_a;
   logic [M-1:0] alu_b;
   logic         alu_en;
   logic [M-1:0] alu_result;
   logic         alu_z;
   logic         alu_n;
   logic         alu_v;
   logic         alu_c;
   logic [1:0]   resp_valid;
   logic [1:0]   resp_ready;
   logic [M-1:0] resp_data;
   logic [3:0]   resp_flags;
   logic [3:0]   nzcv;
   logic         busy;

   modport slave (
      input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, req_setf,
      input  alu_result, alu_z, alu_n, alu_v, alu_c, resp_ready,
      output req_ready, alu_ctrl, alu_a, alu_b, alu_en,
      output resp_valid, resp_data, resp_flags, nzcv, busy
   );

   modport master (
      output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, req_setf,
      output alu_result, alu_z, alu_n, alu_v, alu_c, resp_ready,
      input  req_ready, alu_ctrl, alu_a, alu_b, alu_en,
      input  resp_valid, resp_data, resp_flags, nzcv, busy
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// Shares one ALU/flag datapath between two requesters: round-robin accept,
// one execute cycle, registered result/flags returned, NZCV kept on request.
module alu_share_ctrl #(
   parameter int unsigned M = 4
) (
   input logic           clk,
   input logic           reset,
   alu_share_ctrl_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]   state;
   logic         last_grant;
   logic         grant;
   logic         setf_q;
   logic [3:0]   op_q;
   logic [M-1:0] a_q;
   logic [M-1:0] b_q;
   logic [M-1:0] data_q;
   logic [3:0]   flags_q;
   logic [3:0]   nzcv_q;
   logic         win;
   logic [1:0]   ready;
   logic         accept;

   // Under contention the requester not served last time wins.
   always_comb begin
      win   = 1'b0;
      ready = '0;
      case (bus.req_valid)
         2'b10:   win = 1'b1;
         2'b11:   win = ~last_grant;
         default: win = 1'b0;
      endcase
      if (state == IDLE && bus.req_valid != '0)
         ready = win ? 2'b10 : 2'b01;
   end

   assign accept = |ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant      <= 1'b0;
         setf_q     <= 1'b0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         data_q     <= '0;
         flags_q    <= '0;
         nzcv_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q       <= win ? bus.req_op1 : bus.req_op0;
                  a_q        <= win ? bus.req_a1 : bus.req_a0;
                  b_q        <= win ? bus.req_b1 : bus.req_b0;
                  setf_q     <= bus.req_setf[win];
                  grant      <= win;
                  last_grant <= win;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               data_q  <= bus.alu_result;
               flags_q <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
               if (setf_q)
                  nzcv_q <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
               state <= RESP;
            end
            RESP: begin
               if (bus.resp_ready[grant])
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = ready;
   assign bus.alu_ctrl   = op_q;
   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_en     = (state == EXEC);
   assign bus.resp_valid = (state == RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
   assign bus.resp_data  = data_q;
   assign bus.resp_flags = flags_q;
   assign bus.nzcv       = nzcv_q;
   assign bus.busy       = (state != IDLE);
endmodule
